// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial bit-sequence detector.
// Pattern width and reset pattern are parameters; the pattern can be reloaded
// at run time. MOORE selects combinational (0) or registered (1) match timing.
// Overlapping detection is selected per consumed bit by the overlap input.
// Optional feature macro: SEQDET_COUNT_EN adds a saturating match counter
// driven out on match_count (CNT_W bits wide).
module seq_detector_param #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b0101,
    parameter int                   MOORE     = 0,
    parameter int                   CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 x,
    input  logic                 x_valid,
    input  logic                 overlap,
    input  logic                 pat_load,
    input  logic [PATTERN_W-1:0] pat_in,
`ifdef SEQDET_COUNT_EN
    output logic [CNT_W-1:0]     match_count,
`endif
    output logic                 match
);

    localparam int                FILL_W   = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PATTERN_W - 1);

    // Reject out-of-range configurations at elaboration time.
    if (PATTERN_W < 2 || PATTERN_W > 16 || CNT_W < 1) begin : g_bad_param
        $error("seq_detector_param: illegal PATTERN_W or CNT_W");
    end

    // Saturating increment of the fill counter, capped at PATTERN_W.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
        return (f >= FILL_MAX) ? FILL_MAX : f + 1'b1;
    endfunction

    logic [PATTERN_W-1:0] r_pat;
    // Only the newest PATTERN_W-1 received bits can ever reach the window,
    // so the oldest history bit is not stored.
    logic [PATTERN_W-2:0] r_hist;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_match_q;
    logic [PATTERN_W-1:0] w_window;
    logic                 w_hit;

    assign w_window = {r_hist, x};

    // A hit needs a consumed bit, a full window of fresh bits, and no
    // competing reset or reload (both discard the current bit).
    assign w_hit = x_valid & ~pat_load & ~reset &
                   (w_window == r_pat) & (r_fill >= FILL_ARM);

    // Pattern, history and fill tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pat  <= PATTERN;
            r_hist <= '0;
            r_fill <= '0;
        end else if (pat_load) begin
            r_pat  <= pat_in;
            r_hist <= '0;
            r_fill <= '0;
        end else if (x_valid) begin
            r_hist <= w_window[PATTERN_W-2:0];
            if (w_hit && !overlap) begin
                r_fill <= '0;
            end else begin
                r_fill <= fill_inc(r_fill);
            end
        end
    end

    // Registered match for Moore timing; holds across stalled cycles.
    always_ff @(posedge clk) begin
        if (reset || pat_load) begin
            r_match_q <= 1'b0;
        end else if (x_valid) begin
            r_match_q <= w_hit;
        end
    end

    // Output select; reset forces the output low in its own cycle.
    always_comb begin
        match = 1'b0;
        if (!reset) begin
            match = (MOORE != 0) ? r_match_q : w_hit;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating increment of the match counter; never wraps.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Match counter: cleared only by reset, bumped on every hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_hit) begin
            r_cnt <= cnt_sat_inc(r_cnt);
        end
    end

    assign match_count = r_cnt;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a Mealy instance (CNT_W=8) and a Moore
// instance (CNT_W=2) share one input stream and are compared each cycle
// against a queue-based reference model of the detection rules.
module tb_seq_detector_param;

    localparam int         W   = 4;
    localparam logic [3:0] PAT = 4'b0101;

    logic       clk = 1'b0;
    logic       reset, x, x_valid, overlap, pat_load;
    logic [3:0] pat_in;
    logic       match_mealy, match_moore;
`ifdef SEQDET_COUNT_EN
    logic [7:0] cnt_mealy;
    logic [1:0] cnt_moore;
`endif

    always #5 clk = ~clk;

    seq_detector_param #(.PATTERN_W(W), .PATTERN(PAT), .MOORE(0), .CNT_W(8)) u_mealy (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQDET_COUNT_EN
        .match_count(cnt_mealy),
`endif
        .match(match_mealy)
    );

    seq_detector_param #(.PATTERN_W(W), .PATTERN(PAT), .MOORE(1), .CNT_W(2)) u_moore (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQDET_COUNT_EN
        .match_count(cnt_moore),
`endif
        .match(match_moore)
    );

    // Reference model: fresh bits since the last clear, current pattern,
    // Moore output and both match counts.
    bit         fresh[$];
    logic [3:0] m_pat = PAT;
    logic       m_mq  = 1'b0;
    int         m_cnt8 = 0;
    int         m_cnt2 = 0;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic step(input logic bx, input logic bv, input logic bov,
                        input logic bload, input logic [3:0] bpat,
                        input logic brst, input int exp_m, input string tag);
        logic       hit;
        logic [3:0] win;
        @(negedge clk);
        x = bx; x_valid = bv; overlap = bov; pat_load = bload;
        pat_in = bpat; reset = brst;
        #1;
        hit = 1'b0;
        win = '0;
        if (!brst && !bload && bv && fresh.size() >= W - 1) begin
            for (int i = 0; i < W - 1; i++)
                win = {win[2:0], fresh[fresh.size() - (W - 1) + i]};
            win = {win[2:0], bx};
            hit = (win == m_pat);
        end
        n_vec++;
        assert (match_mealy === hit) else begin
            n_bad++;
            $error("FAIL %s mealy: got %b expected %b", tag, match_mealy, hit);
        end
        assert (match_moore === (m_mq & ~brst)) else begin
            n_bad++;
            $error("FAIL %s moore: got %b expected %b", tag, match_moore, m_mq & ~brst);
        end
        if (exp_m != 2) begin
            assert (match_mealy === exp_m[0]) else begin
                n_bad++;
                $error("FAIL %s directed: got %b expected %b", tag, match_mealy, exp_m[0]);
            end
        end
`ifdef SEQDET_COUNT_EN
        assert (cnt_mealy === 8'(m_cnt8)) else begin
            n_bad++;
            $error("FAIL %s cnt8: got %0d expected %0d", tag, cnt_mealy, m_cnt8);
        end
        assert (cnt_moore === 2'(m_cnt2)) else begin
            n_bad++;
            $error("FAIL %s cnt2: got %0d expected %0d", tag, cnt_moore, m_cnt2);
        end
`endif
        // Advance the model to the state after the coming edge.
        if (brst) begin
            fresh.delete(); m_pat = PAT; m_mq = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (bload) begin
            fresh.delete(); m_pat = bpat; m_mq = 1'b0;
        end else if (bv) begin
            if (hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
            m_mq = hit;
            if (hit && !bov) begin
                fresh.delete();
            end else begin
                fresh.push_back(bx);
                if (fresh.size() > W) void'(fresh.pop_front());
            end
        end
    endtask

    task automatic bits(input logic [15:0] b, input int n, input logic bov,
                        input logic [15:0] e, input string tag);
        logic [15:0] bb, ee;
        bb = b; ee = e;
        for (int i = n - 1; i >= 0; i--)
            step(bb[i], 1'b1, bov, 1'b0, 4'h0, 1'b0, int'(ee[i]), tag);
    endtask

    initial begin
        reset = 1'b1; x = 1'b0; x_valid = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; pat_in = '0;

        step(0, 1, 1, 0, 4'h0, 1, 0, "reset");
        bits(16'b0010_0101, 8, 1, 16'b0000_0001, "plan1");

        step(0, 1, 1, 0, 4'h0, 1, 0, "rst2");
        bits(16'b01_0101, 6, 1, 16'b00_0101, "ovl1");
        step(0, 1, 1, 0, 4'h0, 1, 0, "rst3");
        bits(16'b01_0101, 6, 0, 16'b00_0100, "ovl0");

        step(0, 1, 1, 0, 4'h0, 1, 0, "rst4");
        bits(16'b0101, 4, 1, 16'b0001, "moore");
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 4'h0, 0, 0, "stall");
        step(1, 1, 1, 0, 4'h0, 0, 0, "moore_drop");

        step(1, 1, 1, 1, 4'b1101, 0, 0, "load");
        bits(16'b1101, 4, 1, 16'b0001, "newpat");
        bits(16'b0101, 4, 1, 16'b0000, "oldpat");

        step(0, 1, 1, 0, 4'h0, 1, 0, "rst5");
        bits(16'b010, 3, 1, 16'b000, "pre_rst");
        step(0, 1, 1, 0, 4'h0, 1, 0, "mid_rst");
        bits(16'b1_0101, 5, 1, 16'b0_0001, "post_rst");

        step(0, 1, 1, 0, 4'h0, 1, 0, "rst6");
        bits(16'b010_1010_1010, 11, 1, 16'b000_1010_1010, "sat");
        step(0, 0, 1, 0, 4'h0, 0, 0, "sat_hold");

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), ($urandom_range(0, 7) != 0), 1'($urandom),
                 ($urandom_range(0, 39) == 0), 4'($urandom),
                 ($urandom_range(0, 59) == 0), 2, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-sequence detector; successor to the fixed 4-bit 0101 Mealy/Moore detectors.
- Pattern width and reset pattern are parameters. The pattern is reloadable at run time.
- Mealy or Moore output timing is selected by parameter. Overlapping or non-overlapping detection is selected at run time by an input.
- Input bits carry a valid qualifier. An optional saturating match counter is available.

Parameters:
- PATTERN_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b0101, pattern loaded at reset; first-received bit is the MSB.
- MOORE, 0, output timing: 0 = Mealy (combinational, same cycle), 1 = Moore (registered).
- CNT_W, 8, match counter width; used only with SEQDET_COUNT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is consumed this cycle when high; otherwise state holds.
- overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping. Sampled on each consumed bit.
- pat_load  in  1  load pat_in as the new pattern.
- pat_in  in  PATTERN_W  new pattern, MSB first.
- match  out  1  pattern detected.
- match_count  out  CNT_W  saturating match count; exists only with SEQDET_COUNT_EN.

Behaviour:
- State registers:
  - pat[PATTERN_W-1:0]
  - hist[PATTERN_W-1:0], a shift register of received bits
  - fill, a counter 0..PATTERN_W counting bits received since the last clear
  - match_q (Moore only)
  - cnt (optional)
- Reset (reset=1 at posedge): pat=PATTERN, hist=0, fill=0, match_q=0, cnt=0. match reads 0 in the cycle reset is high, in both modes. Reset beats every other input.
- Window definition: window = {hist[PATTERN_W-2:0], x}.
- hit = x_valid & (window == pat) & (fill >= PATTERN_W-1).
  - No hit is possible before PATTERN_W bits have been consumed since reset, pat_load, or a non-overlap match.
- On a consumed bit (x_valid=1, no pat_load):
  - hist <= window.
  - If hit and overlap=0: fill <= 0.
  - Otherwise: fill <= min(fill+1, PATTERN_W).
- Mealy (MOORE=0):
  - match = hit, combinational from x and x_valid.
  - Zero latency: asserts in the cycle the last pattern bit is presented.
- Moore (MOORE=1):
  - match = match_q.
  - match_q <= hit on each consumed bit; match_q holds while x_valid=0.
  - Latency: one cycle after the last bit's clock edge.
  - Stays high until the next consumed bit.
- pat_load=1:
  - pat <= pat_in; hist <= 0; fill <= 0; match_q <= 0.
  - The x bit in the same cycle is discarded and no hit is produced (Mealy match=0 that cycle).
  - The counter is not cleared.
- Overlap:
  - overlap=1: back-to-back hits are possible on consecutive bits whenever the pattern allows.
  - overlap=0: after a hit, the next hit needs PATTERN_W fresh bits.
- x_valid=0: no state change; Mealy match=0.

Optional Feature:
SEQDET_COUNT_EN:
- Defined:
  - match_count port exists, driven by cnt.
  - cnt increments on every hit and saturates at 2^CNT_W-1 with no wrap.
  - cnt clears only on reset.
  - In Moore mode, cnt increments at the same edge that sets match_q.
- Undefined:
  - No match_count port and no counter logic.
  - Every other behaviour is identical.

Test Plan:
- Mealy, defaults, overlap=1, x_valid=1, bits 0,0,1,0,0,1,0,1 -> match=1 only while the 8th bit is presented; 0 elsewhere.
- Mealy, overlap=1, bits 0,1,0,1,0,1 -> match on bits 4 and 6. Same stream with overlap=0 -> match on bit 4 only. match_count = 2 and 1 respectively.
- MOORE=1, bits 0,1,0,1, then x_valid=0 for 3 cycles -> match rises one cycle after the 4th bit's edge and stays high through the stall. The next consumed bit 1 drops it.
- pat_load with pat_in=4'b1101 mid-stream, then bits 1,1,0,1 -> no match in the load cycle (x discarded); match on the 4th bit after the load. The old pattern 0101 no longer matches.
- reset asserted for 1 cycle after bits 0,1,0 (with overlap=1), then bit 1 -> no match. Subsequent 0,1,0,1 -> match; match_count restarted from 0.
- SEQDET_COUNT_EN with CNT_W=2, overlap=1, stream 0 followed by (1,0) repeated -> hits on bits 4, 6, 8, 10. match_count reads 1, 2, 3, 3 (saturated, no wrap).
